// File: rtl/udma_i2c_cmd_arbiter_if.sv
// Bundles the two command sources, the control-engine byte stream, configuration
// and status of the I2C command arbiter. The arbiter uses the slave view.
interface udma_i2c_cmd_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TO_WIDTH   = 16
);
  logic                  clr_i;
  logic                  cfg_rr_en_i;
  logic [TO_WIDTH-1:0]   cfg_timeout_i;

  logic [DATA_WIDTH-1:0] req0_data_i;
  logic                  req0_last_i;
  logic                  req0_valid_i;
  logic                  req0_ready_o;

  logic [DATA_WIDTH-1:0] req1_data_i;
  logic                  req1_last_i;
  logic                  req1_valid_i;
  logic                  req1_ready_o;

  logic [DATA_WIDTH-1:0] cmd_data_o;
  logic                  cmd_valid_o;
  logic                  cmd_ready_i;

  logic [1:0]            grant_o;
  logic                  busy_o;
  logic                  timeout_evt_o;
  logic                  timeout_src_o;

  modport slave (
    input  clr_i, cfg_rr_en_i, cfg_timeout_i,
    input  req0_data_i, req0_last_i, req0_valid_i,
    output req0_ready_o,
    input  req1_data_i, req1_last_i, req1_valid_i,
    output req1_ready_o,
    output cmd_data_o, cmd_valid_o,
    input  cmd_ready_i,
    output grant_o, busy_o, timeout_evt_o, timeout_src_o
  );

  modport master (
    output clr_i, cfg_rr_en_i, cfg_timeout_i,
    output req0_data_i, req0_last_i, req0_valid_i,
    input  req0_ready_o,
    output req1_data_i, req1_last_i, req1_valid_i,
    input  req1_ready_o,
    input  cmd_data_o, cmd_valid_o,
    output cmd_ready_i,
    input  grant_o, busy_o, timeout_evt_o, timeout_src_o
  );
endinterface

// File: rtl/udma_i2c_cmd_arbiter.sv
// Packet-locking two-source arbiter in front of the I2C control engine byte stream,
// with an owner-idle watchdog that releases a stalled source and drains its leftovers.
module udma_i2c_cmd_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TO_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  udma_i2c_cmd_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  rr_q, rr_d;
  logic [1:0]            drop_q, drop_d;
  logic [TO_WIDTH-1:0]   wd_cnt_q, wd_cnt_d;
  logic                  evt_q, evt_d;
  logic                  src_q, src_d;

  logic [1:0]            req_valid;
  logic [1:0]            req_last;
  logic [1:0]            elig;
  logic                  locked;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_valid;
  logic                  owner_last;
  logic                  owner_hs;

  assign req_valid   = {bus.req1_valid_i, bus.req0_valid_i};
  assign req_last    = {bus.req1_last_i,  bus.req0_last_i};
  assign elig        = req_valid & ~drop_q;
  assign locked      = (state_q == LOCKED);

  assign owner_data  = owner_q ? bus.req1_data_i  : bus.req0_data_i;
  assign owner_valid = owner_q ? bus.req1_valid_i : bus.req0_valid_i;
  assign owner_last  = owner_q ? bus.req1_last_i  : bus.req0_last_i;
  assign owner_hs    = locked & owner_valid & bus.cmd_ready_i & ~bus.clr_i;

  // Owner bytes pass straight through; a dropping source is always ready so its leftovers drain.
  assign bus.cmd_data_o    = locked ? owner_data : '0;
  assign bus.cmd_valid_o   = locked & owner_valid & ~bus.clr_i;
  assign bus.req0_ready_o  = ~bus.clr_i & (drop_q[0] | (locked & ~owner_q & bus.cmd_ready_i));
  assign bus.req1_ready_o  = ~bus.clr_i & (drop_q[1] | (locked &  owner_q & bus.cmd_ready_i));
  assign bus.grant_o       = locked ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy_o        = locked;
  assign bus.timeout_evt_o = evt_q;
  assign bus.timeout_src_o = src_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      drop_q   <= 2'b00;
      wd_cnt_q <= '0;
      evt_q    <= 1'b0;
      src_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      drop_q   <= drop_d;
      wd_cnt_q <= wd_cnt_d;
      evt_q    <= evt_d;
      src_q    <= src_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    drop_d   = drop_q;
    wd_cnt_d = wd_cnt_q;
    evt_d    = 1'b0;
    src_d    = src_q;

    // Drop mode runs regardless of the lock: a drained byte flagged last ends it.
    for (int i = 0; i < 2; i++) begin
      if (drop_q[i] && req_valid[i] && req_last[i]) begin
        drop_d[i] = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (|elig) begin
          state_d = LOCKED;
          if (bus.cfg_rr_en_i) begin
            owner_d = elig[rr_q] ? rr_q : ~rr_q;
          end else begin
            owner_d = ~elig[0];
          end
        end
      end

      LOCKED: begin
        if (owner_hs && owner_last) begin
          state_d  = IDLE;
          rr_d     = ~owner_q;
          wd_cnt_d = '0;
        end else if ((bus.cfg_timeout_i == '0) || owner_valid) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q == bus.cfg_timeout_i - TO_WIDTH'(1)) begin
          // Owner went silent mid-packet: release the lock and discard the rest of its packet.
          state_d         = IDLE;
          drop_d[owner_q] = 1'b1;
          src_d           = owner_q;
          evt_d           = 1'b1;
          rr_d            = ~owner_q;
          wd_cnt_d        = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + TO_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.clr_i) begin
      state_d  = IDLE;
      owner_d  = 1'b0;
      rr_d     = 1'b0;
      drop_d   = 2'b00;
      wd_cnt_d = '0;
      evt_d    = 1'b0;
      src_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_udma_i2c_cmd_arbiter.sv
// Directed bench for the I2C command arbiter: reset, single packet, round-robin and
// fixed-priority contention, watchdog release with drain, downstream stall, mid-packet clear.
module tb_udma_i2c_cmd_arbiter;
  localparam int DW = 8;
  localparam int TW = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_i = ~clk_i;

  udma_i2c_cmd_arbiter_if #(.DATA_WIDTH(DW), .TO_WIDTH(TW)) bus ();

  udma_i2c_cmd_arbiter #(.DATA_WIDTH(DW), .TO_WIDTH(TW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_sources();
    bus.req0_data_i  = '0;
    bus.req0_last_i  = 1'b0;
    bus.req0_valid_i = 1'b0;
    bus.req1_data_i  = '0;
    bus.req1_last_i  = 1'b0;
    bus.req1_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i             = 1'b1;
    bus.clr_i         = 1'b0;
    bus.cfg_rr_en_i   = 1'b1;
    bus.cfg_timeout_i = '0;
    bus.cmd_ready_i   = 1'b1;
    idle_sources();
    #12;
    n_checks++; if (bus.grant_o !== 2'b00) $display("[TB] FAIL reset_grant: got %b expected 00", bus.grant_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.cmd_valid_o !== 1'b0) $display("[TB] FAIL reset_cmd_valid: got %b expected 0", bus.cmd_valid_o); else n_pass++;
    n_checks++; if (bus.cmd_data_o !== 8'h00) $display("[TB] FAIL reset_cmd_data: got %h expected 00", bus.cmd_data_o); else n_pass++;
    n_checks++; if (bus.req0_ready_o !== 1'b0) $display("[TB] FAIL reset_ready0: got %b expected 0", bus.req0_ready_o); else n_pass++;
    n_checks++; if (bus.req1_ready_o !== 1'b0) $display("[TB] FAIL reset_ready1: got %b expected 0", bus.req1_ready_o); else n_pass++;
    n_checks++; if (bus.timeout_evt_o !== 1'b0) $display("[TB] FAIL reset_evt: got %b expected 0", bus.timeout_evt_o); else n_pass++;
    n_checks++; if (bus.timeout_src_o !== 1'b0) $display("[TB] FAIL reset_src: got %b expected 0", bus.timeout_src_o); else n_pass++;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] pkt [4];
    pkt = '{8'h00, 8'h80, 8'h5A, 8'h20};
    idle_sources();
    do_clear();
    bus.cfg_rr_en_i   = 1'b1;
    bus.cfg_timeout_i = '0;
    bus.cmd_ready_i   = 1'b1;
    bus.req0_data_i   = pkt[0];
    bus.req0_valid_i  = 1'b1;
    #1;
    n_checks++; if (bus.grant_o !== 2'b00) $display("[TB] FAIL single_arb_grant: got %b expected 00", bus.grant_o); else n_pass++;
    n_checks++; if (bus.cmd_valid_o !== 1'b0) $display("[TB] FAIL single_arb_valid: got %b expected 0", bus.cmd_valid_o); else n_pass++;
    n_checks++; if (bus.req0_ready_o !== 1'b0) $display("[TB] FAIL single_arb_ready: got %b expected 0", bus.req0_ready_o); else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.req0_data_i = pkt[i];
      bus.req0_last_i = (i == 3);
      #1;
      n_checks++; if (bus.grant_o !== 2'b01) $display("[TB] FAIL single_grant[%0d]: got %b expected 01", i, bus.grant_o); else n_pass++;
      n_checks++; if (bus.cmd_valid_o !== 1'b1) $display("[TB] FAIL single_valid[%0d]: got %b expected 1", i, bus.cmd_valid_o); else n_pass++;
      n_checks++; if (bus.cmd_data_o !== pkt[i]) $display("[TB] FAIL single_data[%0d]: got %h expected %h", i, bus.cmd_data_o, pkt[i]); else n_pass++;
      tick();
    end
    idle_sources();
    #1;
    n_checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL single_release_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.grant_o !== 2'b00) $display("[TB] FAIL single_release_grant: got %b expected 00", bus.grant_o); else n_pass++;
  endtask

  task automatic present(input int p0, input int i0, input int p1, input int i1);
    bus.req0_data_i  = {1'b0, 3'(p0), 4'(i0)};
    bus.req0_last_i  = (i0 == 2);
    bus.req0_valid_i = 1'b1;
    bus.req1_data_i  = {1'b1, 3'(p1), 4'(i1)};
    bus.req1_last_i  = (i1 == 2);
    bus.req1_valid_i = 1'b1;
  endtask

  // Both sources stream 3-byte packets; byte = {source, packet number, byte index}.
  task automatic test_contention(input logic rr_en);
    int         pkt_n [2];
    int         idx   [2];
    logic       own;
    logic [7:0] exp;
    logic [1:0] exp_grant;
    idle_sources();
    do_clear();
    bus.cfg_rr_en_i   = rr_en;
    bus.cfg_timeout_i = '0;
    bus.cmd_ready_i   = 1'b1;
    pkt_n = '{0, 0};
    idx   = '{0, 0};
    for (int k = 0; k < 3; k++) begin
      own       = rr_en ? k[0] : 1'b0;
      exp_grant = own ? 2'b10 : 2'b01;
      present(pkt_n[0], idx[0], pkt_n[1], idx[1]);
      #1;
      n_checks++; if (bus.grant_o !== 2'b00) $display("[TB] FAIL contend_bubble_grant rr=%0b pkt %0d: got %b expected 00", rr_en, k, bus.grant_o); else n_pass++;
      n_checks++; if (bus.cmd_valid_o !== 1'b0) $display("[TB] FAIL contend_bubble_valid rr=%0b pkt %0d: got %b expected 0", rr_en, k, bus.cmd_valid_o); else n_pass++;
      tick();
      for (int b = 0; b < 3; b++) begin
        present(pkt_n[0], idx[0], pkt_n[1], idx[1]);
        exp = {own, 3'(pkt_n[own]), 4'(b)};
        #1;
        n_checks++; if (bus.grant_o !== exp_grant) $display("[TB] FAIL contend_grant rr=%0b pkt %0d byte %0d: got %b expected %b", rr_en, k, b, bus.grant_o, exp_grant); else n_pass++;
        n_checks++; if (bus.cmd_data_o !== exp) $display("[TB] FAIL contend_data rr=%0b pkt %0d byte %0d: got %h expected %h", rr_en, k, b, bus.cmd_data_o, exp); else n_pass++;
        n_checks++; if ((own ? bus.req0_ready_o : bus.req1_ready_o) !== 1'b0) $display("[TB] FAIL contend_nonowner_ready rr=%0b pkt %0d byte %0d: got 1 expected 0", rr_en, k, b); else n_pass++;
        tick();
        idx[own] = idx[own] + 1;
      end
      idx[own]   = 0;
      pkt_n[own] = pkt_n[own] + 1;
    end
    idle_sources();
    #1;
  endtask

  task automatic test_watchdog();
    idle_sources();
    do_clear();
    bus.cfg_rr_en_i   = 1'b1;
    bus.cfg_timeout_i = 16'd4;
    bus.cmd_ready_i   = 1'b1;
    bus.req1_data_i   = 8'h80;
    bus.req1_valid_i  = 1'b1;
    #1;
    tick();
    n_checks++; if (bus.grant_o !== 2'b10) $display("[TB] FAIL wd_grant1: got %b expected 10", bus.grant_o); else n_pass++;
    n_checks++; if (bus.cmd_data_o !== 8'h80) $display("[TB] FAIL wd_byte0: got %h expected 80", bus.cmd_data_o); else n_pass++;
    tick();
    bus.req1_data_i = 8'h11;
    #1;
    n_checks++; if (bus.cmd_data_o !== 8'h11) $display("[TB] FAIL wd_byte1: got %h expected 11", bus.cmd_data_o); else n_pass++;
    tick();
    bus.req1_valid_i = 1'b0;
    bus.req0_data_i  = 8'h42;
    bus.req0_last_i  = 1'b1;
    bus.req0_valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (bus.grant_o !== 2'b10) $display("[TB] FAIL wd_hold_grant[%0d]: got %b expected 10", c, bus.grant_o); else n_pass++;
      n_checks++; if (bus.timeout_evt_o !== 1'b0) $display("[TB] FAIL wd_early_evt[%0d]: got %b expected 0", c, bus.timeout_evt_o); else n_pass++;
      tick();
    end
    bus.req1_data_i  = 8'h33;
    bus.req1_last_i  = 1'b0;
    bus.req1_valid_i = 1'b1;
    #1;
    n_checks++; if (bus.timeout_evt_o !== 1'b1) $display("[TB] FAIL wd_evt: got %b expected 1", bus.timeout_evt_o); else n_pass++;
    n_checks++; if (bus.timeout_src_o !== 1'b1) $display("[TB] FAIL wd_src: got %b expected 1", bus.timeout_src_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL wd_release_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.req1_ready_o !== 1'b1) $display("[TB] FAIL wd_drain_ready0: got %b expected 1", bus.req1_ready_o); else n_pass++;
    n_checks++; if (bus.cmd_valid_o !== 1'b0) $display("[TB] FAIL wd_drain_valid: got %b expected 0", bus.cmd_valid_o); else n_pass++;
    tick();
    bus.req1_data_i = 8'h20;
    bus.req1_last_i = 1'b1;
    #1;
    n_checks++; if (bus.timeout_evt_o !== 1'b0) $display("[TB] FAIL wd_evt_pulse: got %b expected 0", bus.timeout_evt_o); else n_pass++;
    n_checks++; if (bus.grant_o !== 2'b01) $display("[TB] FAIL wd_grant0: got %b expected 01", bus.grant_o); else n_pass++;
    n_checks++; if (bus.cmd_data_o !== 8'h42) $display("[TB] FAIL wd_req0_data: got %h expected 42", bus.cmd_data_o); else n_pass++;
    n_checks++; if (bus.req1_ready_o !== 1'b1) $display("[TB] FAIL wd_drain_ready1: got %b expected 1", bus.req1_ready_o); else n_pass++;
    tick();
    idle_sources();
    #1;
    n_checks++; if (bus.req1_ready_o !== 1'b0) $display("[TB] FAIL wd_drop_cleared: got %b expected 0", bus.req1_ready_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL wd_end_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.timeout_src_o !== 1'b1) $display("[TB] FAIL wd_src_held: got %b expected 1", bus.timeout_src_o); else n_pass++;
  endtask

  task automatic test_stall();
    int bad;
    idle_sources();
    do_clear();
    bus.cfg_rr_en_i   = 1'b1;
    bus.cfg_timeout_i = 16'd4;
    bus.cmd_ready_i   = 1'b0;
    bus.req0_data_i   = 8'hA1;
    bus.req0_valid_i  = 1'b1;
    #1;
    tick();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus.busy_o !== 1'b1 || bus.timeout_evt_o !== 1'b0 || bus.cmd_valid_o !== 1'b1 || bus.req0_ready_o !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("[TB] FAIL stall_hold: got %0d bad cycles expected 0", bad); else n_pass++;
    bus.cmd_ready_i = 1'b1;
    #1;
    n_checks++; if (bus.cmd_data_o !== 8'hA1) $display("[TB] FAIL stall_byte0: got %h expected a1", bus.cmd_data_o); else n_pass++;
    n_checks++; if (bus.req0_ready_o !== 1'b1) $display("[TB] FAIL stall_ready: got %b expected 1", bus.req0_ready_o); else n_pass++;
    tick();
    bus.req0_data_i = 8'hA2;
    bus.req0_last_i = 1'b1;
    #1;
    n_checks++; if (bus.cmd_data_o !== 8'hA2) $display("[TB] FAIL stall_byte1: got %h expected a2", bus.cmd_data_o); else n_pass++;
    tick();
    idle_sources();
    #1;
    n_checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL stall_end_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.timeout_evt_o !== 1'b0) $display("[TB] FAIL stall_end_evt: got %b expected 0", bus.timeout_evt_o); else n_pass++;
  endtask

  task automatic test_clr_mid();
    idle_sources();
    do_clear();
    bus.cfg_rr_en_i   = 1'b1;
    bus.cfg_timeout_i = 16'd2;
    bus.cmd_ready_i   = 1'b1;
    bus.req1_data_i   = 8'h55;
    bus.req1_valid_i  = 1'b1;
    #1;
    tick();
    tick();
    bus.req1_valid_i = 1'b0;
    #1;
    tick();
    tick();
    bus.req0_data_i  = 8'hC0;
    bus.req0_valid_i = 1'b1;
    #1;
    n_checks++; if (bus.req1_ready_o !== 1'b1) $display("[TB] FAIL clr_pre_drop: got %b expected 1", bus.req1_ready_o); else n_pass++;
    tick();
    n_checks++; if (bus.grant_o !== 2'b01) $display("[TB] FAIL clr_pre_grant: got %b expected 01", bus.grant_o); else n_pass++;
    n_checks++; if (bus.cmd_data_o !== 8'hC0) $display("[TB] FAIL clr_pre_data: got %h expected c0", bus.cmd_data_o); else n_pass++;
    tick();
    bus.req0_data_i = 8'hC1;
    bus.clr_i       = 1'b1;
    #1;
    tick();
    bus.clr_i        = 1'b0;
    bus.req0_valid_i = 1'b0;
    #1;
    n_checks++; if (bus.grant_o !== 2'b00) $display("[TB] FAIL clr_grant: got %b expected 00", bus.grant_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL clr_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.req1_ready_o !== 1'b0) $display("[TB] FAIL clr_drop_flag: got %b expected 0", bus.req1_ready_o); else n_pass++;
    n_checks++; if (bus.timeout_src_o !== 1'b0) $display("[TB] FAIL clr_src: got %b expected 0", bus.timeout_src_o); else n_pass++;
    bus.req1_data_i  = 8'hD0;
    bus.req1_last_i  = 1'b1;
    bus.req1_valid_i = 1'b1;
    #1;
    tick();
    n_checks++; if (bus.grant_o !== 2'b10) $display("[TB] FAIL clr_next_grant: got %b expected 10", bus.grant_o); else n_pass++;
    n_checks++; if (bus.cmd_data_o !== 8'hD0) $display("[TB] FAIL clr_next_data: got %h expected d0", bus.cmd_data_o); else n_pass++;
    tick();
    idle_sources();
    #1;
    n_checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL clr_next_release: got %b expected 0", bus.busy_o); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    test_reset();
    test_single();
    test_contention(1'b1);
    test_contention(1'b0);
    test_watchdog();
    test_stall();
    test_clr_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
